// File: rtl/rib_pkg.sv
// rib_pkg: shared FSM states, master indices and defaults for the RIB arbiter
package rib_pkg;

   typedef enum logic {
      RIB_ARB_IDLE = 1'b0,
      RIB_ARB_BUSY = 1'b1
   } rib_arb_state_e;

   localparam int RIB_M_JTAG          = 0;
   localparam int RIB_M_UART          = 1;
   localparam int RIB_M_EX            = 2;
   localparam int RIB_M_PC            = 3;
   localparam int RIB_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/rib_arb_pick.sv
// rib_arb_pick: picks the first requester at or above ptr, wrapping around; ptr=0 gives fixed priority
module rib_arb_pick
   import rib_pkg::*;
#(
   parameter int NUM_M = 4,
   parameter int PW    = 2
) (
   input  logic [NUM_M-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [NUM_M-1:0] win
);

   logic found;

   // Walk the ring starting at ptr and keep only the first requester found
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_M; k++)
         for (int i = 0; i < NUM_M; i++)
            if (!found && req[i] && i == (int'(ptr) + k) % NUM_M) begin
               win[i] = 1'b1;
               found  = 1'b1;
            end
   end

endmodule

// File: rtl/rib_arb.sv
// rib_arb: shares the RIB slave port between jtag, uart, core ex and core pc; RIB_ARB_RR_EN selects round-robin
module rib_arb
   import rib_pkg::*;
#(
   parameter int               NUM_M     = 4,
   parameter int               AW        = 32,
   parameter int               DW        = 32,
   parameter int               TIMEOUT   = RIB_DEFAULT_TIMEOUT,
   parameter logic [NUM_M-1:0] HOLD_MASK = 4'b1100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_M-1:0]    m_req_i,
   input  logic [NUM_M-1:0]    m_we_i,
   input  logic [NUM_M*AW-1:0] m_addr_i,
   input  logic [NUM_M*DW-1:0] m_data_i,
   output logic [DW-1:0]       m_data_o,
   output logic [NUM_M-1:0]    m_ack_o,
   output logic [NUM_M-1:0]    grant_o,
   output logic                s_req_o,
   output logic                s_we_o,
   output logic [AW-1:0]       s_addr_o,
   output logic [DW-1:0]       s_data_o,
   input  logic [DW-1:0]       s_data_i,
   input  logic                s_ack_i,
   output logic                hold_flag_o,
   output logic                timeout_o
);

   localparam int              CW       = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam int              PW       = NUM_M > 1 ? $clog2(NUM_M) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

   rib_arb_state_e   state, state_n;
   logic [NUM_M-1:0] grant, grant_n, win;
   logic [CW-1:0]    cnt, cnt_n;
   logic [PW-1:0]    ptr;
   logic             busy, ack_ev, to_ev;

   rib_arb_pick #(.NUM_M(NUM_M), .PW(PW)) u_pick (
      .req(m_req_i),
      .ptr(ptr),
      .win(win)
   );

`ifdef RIB_ARB_RR_EN
   logic [PW-1:0] ptr_n;

   // Move the search start just past each newly granted master
   always_comb begin
      ptr_n = ptr;
      for (int i = 0; i < NUM_M; i++)
         if (state == RIB_ARB_IDLE && win[i]) ptr_n = PW'((i + 1) % NUM_M);
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (rst) ptr <= '0;
      else     ptr <= ptr_n;
   end
`else
   assign ptr = '0;
`endif

   assign busy   = state == RIB_ARB_BUSY;
   assign ack_ev = busy && s_ack_i;
   // A real ack in the last allowed cycle beats the forced completion
   assign to_ev  = busy && !s_ack_i && TIMEOUT != 0 && cnt == CNT_LAST;

   // Transaction sequencing: grant from IDLE, release on ack or timeout, otherwise age the wait counter
   always_comb begin
      state_n = state;
      grant_n = grant;
      cnt_n   = cnt;
      if (!busy) begin
         if (|m_req_i) begin
            state_n = RIB_ARB_BUSY;
            grant_n = win;
            cnt_n   = '0;
         end
      end else if (ack_ev || to_ev) begin
         state_n = RIB_ARB_IDLE;
         grant_n = '0;
         cnt_n   = '0;
      end else if (cnt != '1) begin
         cnt_n = cnt + 1'b1;
      end
   end

   // State, grant and wait-counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RIB_ARB_IDLE;
         grant <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         cnt   <= cnt_n;
      end
   end

   // Route the granted master's request fields to the slave; zero when idle
   always_comb begin
      s_we_o   = 1'b0;
      s_addr_o = '0;
      s_data_o = '0;
      for (int i = 0; i < NUM_M; i++)
         if (busy && grant[i]) begin
            s_we_o   = m_we_i[i];
            s_addr_o = m_addr_i[i*AW +: AW];
            s_data_o = m_data_i[i*DW +: DW];
         end
   end

   assign s_req_o     = busy;
   assign grant_o     = grant;
   assign m_ack_o     = (ack_ev || to_ev) ? grant : '0;
   assign m_data_o    = ack_ev ? s_data_i : '0;
   assign timeout_o   = to_ev;
   assign hold_flag_o = |(m_req_i & HOLD_MASK & ~m_ack_o);

endmodule

// File: tb/tb_rib_arb.sv
// tb_rib_arb: directed and randomized checks of rib_arb against a transaction-level model
module tb_rib_arb;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    m_req = '0, m_we = '0;
   logic [N*AW-1:0] m_addr = '0;
   logic [N*DW-1:0] m_data = '0;
   logic [DW-1:0]   m_data_o, s_data_o;
   logic [DW-1:0]   s_data_i = '0;
   logic [N-1:0]    m_ack_o, grant_o;
   logic            s_req_o, s_we_o, hold_flag_o, timeout_o;
   logic [AW-1:0]   s_addr_o;
   logic            s_ack = 1'b0;

   always #5 clk = ~clk;

   rib_arb #(.NUM_M(N), .AW(AW), .DW(DW), .TIMEOUT(TO), .HOLD_MASK(4'b1100)) dut (
      .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_data_i(m_data),
      .m_data_o(m_data_o), .m_ack_o(m_ack_o), .grant_o(grant_o), .s_req_o(s_req_o), .s_we_o(s_we_o),
      .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack),
      .hold_flag_o(hold_flag_o), .timeout_o(timeout_o)
   );

   int          checks = 0, errors = 0;
   int          new_pct = 0, slave_mode = 0, wait_n = 0, wcnt = 0;
   bit          renew = 1'b0, rand_rst = 1'b0;
   logic [31:0] sdata_fixed = '0;
   logic [N-1:0] ack_seen = '0;

   // Model: owner of the current transaction (-1 when none), its age, and the rotating start
   int own = -1, age = 0, rrp = 0;
   bit started = 1'b0;

   logic [N-1:0]  e_grant, e_ack;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_sdata, e_mdata;
   logic          e_busy, e_we, e_hold, e_ackev, e_toev;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic int pick(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++)
         if (((32'(r) >> ((p + k) % N)) & 32'd1) != 0) return (p + k) % N;
      return -1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         own <= -1; age <= 0; rrp <= 0; started <= 1'b1;
      end else if (own < 0) begin
         if (m_req != 0) begin
            own <= pick(m_req, rrp);
            age <= 0;
`ifdef RIB_ARB_RR_EN
            rrp <= (pick(m_req, rrp) + 1) % N;
`endif
         end
      end else if (s_ack || (TO != 0 && age == TO - 1)) begin
         own <= -1;
      end else begin
         age <= age + 1;
      end
   end

   initial forever begin
      @(negedge clk);
      ack_seen = m_ack_o;
      if (started) begin
         e_busy  = own >= 0;
         e_ackev = e_busy && s_ack;
         e_toev  = e_busy && !s_ack && TO != 0 && age == TO - 1;
         e_grant = e_busy ? N'(32'd1 << own) : '0;
         e_ack   = (e_ackev || e_toev) ? e_grant : '0;
         e_we    = e_busy && (((32'(m_we) >> own) & 32'd1) != 0);
         e_addr  = e_busy ? AW'(m_addr >> (own * AW)) : '0;
         e_sdata = e_busy ? DW'(m_data >> (own * DW)) : '0;
         e_mdata = e_ackev ? s_data_i : '0;
         e_hold  = |(m_req & 4'b1100 & ~e_ack);
         chk("grant",   32'(grant_o),     32'(e_grant));
         chk("s_req",   32'(s_req_o),     32'(e_busy));
         chk("s_we",    32'(s_we_o),      32'(e_we));
         chk("s_addr",  s_addr_o,         e_addr);
         chk("s_data",  s_data_o,         e_sdata);
         chk("m_ack",   32'(m_ack_o),     32'(e_ack));
         chk("m_data",  m_data_o,         e_mdata);
         chk("timeout", 32'(timeout_o),   32'(e_toev));
         chk("hold",    32'(hold_flag_o), 32'(e_hold));
      end
   end

   // Masters hold requests until acked; the slave acks after wait_n cycles, never, or at random
   initial forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
         if (ack_seen[i]) begin
            m_req[i] = 1'b0;
            if (renew) m_req[i] = 1'b1;
         end else if (!m_req[i] && $urandom_range(99) < new_pct) begin
            m_req[i] = 1'b1;
            m_we[i] = 1'($urandom_range(1));
            m_addr[i*AW +: AW] = $urandom;
            m_data[i*DW +: DW] = $urandom;
         end
      if (rand_rst) rst = $urandom_range(63) == 0;
      if (!s_req_o) begin
         wcnt = 0;
         s_ack = slave_mode == 2 && $urandom_range(2) == 0;
      end else begin
         s_ack = slave_mode == 0 ? wcnt >= wait_n : slave_mode == 2 ? $urandom_range(2) == 0 : 1'b0;
         wcnt++;
      end
      s_data_i = slave_mode == 2 ? $urandom : sdata_fixed;
   end

   task automatic step;
      @(posedge clk); #2;
   endtask

   task automatic wait_ack(output logic [N-1:0] a);
      a = '0;
      for (int n = 0; n < 40 && a == 0; n++) begin
         @(negedge clk);
         a = m_ack_o;
      end
      if (a == 0) begin
         checks++; errors++;
         $display("FAIL ack_wait: no m_ack_o within 40 cycles, expected a completion");
      end
   endtask

   logic [N-1:0] a;
`ifdef RIB_ARB_RR_EN
   int ord[5] = '{0, 1, 2, 3, 0};
`else
   int ord[5] = '{0, 0, 0, 0, 0};
`endif
   int t2_ord[3]  = '{0, 2, 3};
   bit t2_hold[3] = '{1'b1, 1'b1, 1'b0};

   initial begin
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_grant", 32'(grant_o), 32'h0);
      chk("rst_sreq",  32'(s_req_o), 32'h0);
      chk("rst_ack",   32'(m_ack_o), 32'h0);
      chk("rst_addr",  s_addr_o,     32'h0);
      // Single write from core ex with a zero-wait slave
      step;
      m_we[2] = 1'b1;
      m_addr[2*AW +: AW] = 32'h1000_0004;
      m_data[2*DW +: DW] = 32'hA5A5_0001;
      slave_mode = 0; wait_n = 0;
      m_req = 4'b0100;
      @(negedge clk);
      chk("t1_c0_grant", 32'(grant_o),     32'h0);
      chk("t1_c0_hold",  32'(hold_flag_o), 32'h1);
      @(negedge clk);
      chk("t1_grant", 32'(grant_o),     32'h4);
      chk("t1_sreq",  32'(s_req_o),     32'h1);
      chk("t1_addr",  s_addr_o,         32'h1000_0004);
      chk("t1_wdata", s_data_o,         32'hA5A5_0001);
      chk("t1_ack",   32'(m_ack_o),     32'h4);
      chk("t1_hold",  32'(hold_flag_o), 32'h0);
      @(negedge clk);
      chk("t1_idle", 32'(s_req_o), 32'h0);
      // Contention under the selected priority scheme, two wait states
      step;
      wait_n = 2;
      m_req = 4'b1101;
      for (int k = 0; k < 3; k++) begin
         wait_ack(a);
`ifdef RIB_ARB_RR_EN
         chk("t2_ack_any", 32'(a != 0), 32'h1);
`else
         chk("t2_order", 32'(a), 32'(32'd1 << t2_ord[k]));
         chk("t2_hold",  32'(hold_flag_o), 32'(t2_hold[k]));
`endif
      end
      step; step;
      // Forced completion of a core pc read with a dead slave
      m_we[3] = 1'b0;
      sdata_fixed = 32'h1234_5678;
      slave_mode = 1;
      m_req = 4'b1000;
      @(negedge clk);
      for (int c = 1; c < 4; c++) begin
         @(negedge clk);
         chk("t3_wait_to",  32'(timeout_o), 32'h0);
         chk("t3_wait_ack", 32'(m_ack_o),   32'h0);
      end
      @(negedge clk);
      chk("t3_ack",   32'(m_ack_o),   32'h8);
      chk("t3_data",  m_data_o,       32'h0);
      chk("t3_to",    32'(timeout_o), 32'h1);
      @(negedge clk);
      chk("t3_idle", 32'(grant_o), 32'h0);
      // Reset in the second busy cycle aborts without an ack
      step;
      m_we[1] = 1'b1;
      m_req = 4'b0010;
      step;
      step;
      rst = 1'b1;
      @(negedge clk);
      chk("t4_busy2", 32'(grant_o), 32'h2);
      step;
      rst = 1'b0;
      slave_mode = 0; wait_n = 0;
      @(negedge clk);
      chk("t4_sreq",  32'(s_req_o), 32'h0);
      chk("t4_grant", 32'(grant_o), 32'h0);
      chk("t4_ack",   32'(m_ack_o), 32'h0);
      @(negedge clk);
      chk("t4_regrant", 32'(grant_o), 32'h2);
      chk("t4_reack",   32'(m_ack_o), 32'h2);
      // Read data returned on the third cycle after the request
      step; step;
      m_we[1] = 1'b0;
      sdata_fixed = 32'hDEAD_BEEF;
      wait_n = 2;
      m_req = 4'b0010;
      @(negedge clk);
      for (int c = 1; c < 3; c++) begin
         @(negedge clk);
         chk("t6_early_ack",  32'(m_ack_o), 32'h0);
         chk("t6_early_data", m_data_o,     32'h0);
      end
      @(negedge clk);
      chk("t6_data", m_data_o,     32'hDEAD_BEEF);
      chk("t6_ack",  32'(m_ack_o), 32'h2);
      @(negedge clk);
      chk("t6_after_ack",  32'(m_ack_o), 32'h0);
      chk("t6_after_data", m_data_o,     32'h0);
      // All masters requesting back to back
      step;
      wait_n = 0;
      renew = 1'b1;
      m_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack(a);
         chk("t5_order", 32'(a), 32'(32'd1 << ord[k]));
      end
      renew = 1'b0;
      for (int n = 0; n < 60 && m_req != 0; n++) @(negedge clk);
      chk("t5_drain", 32'(m_req), 32'h0);
      // Random traffic with random slave latency and occasional resets
      new_pct = 30;
      slave_mode = 2;
      rand_rst = 1'b1;
      repeat (800) @(posedge clk);
      rand_rst = 1'b0;
      rst = 1'b0;
      new_pct = 0;
      for (int n = 0; n < 200 && m_req != 0; n++) @(negedge clk);
      chk("rand_drain", 32'(m_req), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
